// File: rtl/axil_master_bridge_if.sv
// axil_master_bridge_if: native PicoRV32 memory bus plus AXI4-lite master channels
interface axil_master_bridge_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        mem_axi_awvalid;
  logic        mem_axi_awready;
  logic [31:0] mem_axi_awaddr;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_wvalid;
  logic        mem_axi_wready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid;
  logic        mem_axi_bready;
  logic        mem_axi_arvalid;
  logic        mem_axi_arready;
  logic [31:0] mem_axi_araddr;
  logic [2:0]  mem_axi_arprot;
  logic        mem_axi_rvalid;
  logic        mem_axi_rready;
  logic [31:0] mem_axi_rdata;
  modport master (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata, mem_err,
    output mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
    input  mem_axi_awready,
    output mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
    input  mem_axi_wready,
    input  mem_axi_bvalid,
    output mem_axi_bready,
    output mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
    input  mem_axi_arready,
    input  mem_axi_rvalid, mem_axi_rdata,
    output mem_axi_rready
  );
  modport slave (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata, mem_err,
    input  mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
    output mem_axi_awready,
    input  mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
    output mem_axi_wready,
    output mem_axi_bvalid,
    input  mem_axi_bready,
    input  mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
    output mem_axi_arready,
    output mem_axi_rvalid, mem_axi_rdata,
    input  mem_axi_rready
  );
endinterface

// File: rtl/axil_master_bridge.sv
// axil_master_bridge: PicoRV32 native memory bus to single-outstanding AXI4-lite master with response timeout
module axil_master_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input logic                  clk,
  input logic                  resetn,
  axil_master_bridge_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;
  typedef struct packed {
    state_t      state;
    logic [31:0] cnt;
    logic        ready;
    logic        err;
    logic [31:0] rdata;
    logic        awvalid;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bready;
    logic        arvalid;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rready;
  } regs_t;
  regs_t r_q, w_d;
  logic  w_rd, w_busy, w_tmo;
  assign w_rd   = r_q.state inside {RD_ADDR, RD_DATA};
  assign w_busy = w_rd || r_q.state inside {WR_REQ, WR_RESP};
  assign w_tmo  = TIMEOUT_CYCLES != 0 && w_busy && r_q.cnt == TIMEOUT_CYCLES - 1;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_q        <= '0;
      r_q.bready <= 1'b1;
      r_q.rready <= 1'b1;
    end else begin
      r_q <= w_d;
    end
  end
  always_comb begin
    w_d       = r_q;
    w_d.ready = 1'b0;
    w_d.err   = 1'b0;
    w_d.cnt   = w_busy ? r_q.cnt + 32'd1 : 32'd0;
    case (r_q.state)
      IDLE: begin
        w_d.rready = 1'b1;
        w_d.bready = 1'b1;
        if (bus.mem_valid && bus.mem_wstrb == 4'd0) begin
          w_d.state   = RD_ADDR;
          w_d.araddr  = bus.mem_addr;
          w_d.arprot  = bus.mem_instr ? 3'b100 : 3'b000;
          w_d.arvalid = 1'b1;
          w_d.rready  = 1'b0;
        end else if (bus.mem_valid) begin
          w_d.state   = WR_REQ;
          w_d.awaddr  = bus.mem_addr;
          w_d.awprot  = 3'b000;
          w_d.wdata   = bus.mem_wdata;
          w_d.wstrb   = bus.mem_wstrb;
          w_d.awvalid = 1'b1;
          w_d.wvalid  = 1'b1;
          w_d.bready  = 1'b0;
        end
      end
      RD_ADDR: begin
        if (bus.mem_axi_arready) begin
          w_d.state   = RD_DATA;
          w_d.arvalid = 1'b0;
          w_d.rready  = 1'b1;
        end
      end
      RD_DATA: begin
        if (bus.mem_axi_rvalid) begin
          w_d.state  = DONE;
          w_d.rready = 1'b0;
          w_d.rdata  = bus.mem_axi_rdata;
          w_d.ready  = 1'b1;
        end
      end
      WR_REQ: begin
        w_d.awvalid = r_q.awvalid && !bus.mem_axi_awready;
        w_d.wvalid  = r_q.wvalid && !bus.mem_axi_wready;
        if (!w_d.awvalid && !w_d.wvalid) begin
          w_d.state  = WR_RESP;
          w_d.bready = 1'b1;
        end
      end
      WR_RESP: begin
        if (bus.mem_axi_bvalid) begin
          w_d.state  = DONE;
          w_d.bready = 1'b0;
          w_d.ready  = 1'b1;
        end
      end
      default: begin
        w_d.state  = IDLE;
        w_d.rready = 1'b1;
        w_d.bready = 1'b1;
      end
    endcase
    if (w_tmo && w_d.state != DONE) begin
      w_d.state   = DONE;
      w_d.arvalid = 1'b0;
      w_d.awvalid = 1'b0;
      w_d.wvalid  = 1'b0;
      w_d.rready  = 1'b0;
      w_d.bready  = 1'b0;
      w_d.ready   = 1'b1;
      w_d.err     = 1'b1;
      w_d.rdata   = w_rd ? ERR_RDATA : r_q.rdata;
    end
  end
  assign bus.mem_ready       = r_q.ready;
  assign bus.mem_err         = r_q.err;
  assign bus.mem_rdata       = r_q.rdata;
  assign bus.mem_axi_awvalid = r_q.awvalid;
  assign bus.mem_axi_awaddr  = r_q.awaddr;
  assign bus.mem_axi_awprot  = r_q.awprot;
  assign bus.mem_axi_wvalid  = r_q.wvalid;
  assign bus.mem_axi_wdata   = r_q.wdata;
  assign bus.mem_axi_wstrb   = r_q.wstrb;
  assign bus.mem_axi_bready  = r_q.bready;
  assign bus.mem_axi_arvalid = r_q.arvalid;
  assign bus.mem_axi_araddr  = r_q.araddr;
  assign bus.mem_axi_arprot  = r_q.arprot;
  assign bus.mem_axi_rready  = r_q.rready;
endmodule

// File: tb/tb_axil_master_bridge.sv
// tb_axil_master_bridge: directed and randomized self-checking bench with a behavioural slave and memory model
module tb_axil_master_bridge;
  localparam int TMO = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  logic clk = 1'b0;
  logic resetn;
  int checks = 0;
  int errors = 0;
  logic [31:0] last_rdata = 32'h0;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];
  axil_master_bridge_if bus();
  axil_master_bridge #(.TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERR)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) o[8*i +: 8] = d[8*i +: 8];
    return o;
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : a ^ 32'h0F0F_1234;
  endfunction
  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : a ^ 32'h0F0F_1234;
  endfunction
  task automatic slave_idle();
    bus.mem_axi_arready = 1'b0;
    bus.mem_axi_awready = 1'b0;
    bus.mem_axi_wready  = 1'b0;
    bus.mem_axi_rvalid  = 1'b0;
    bus.mem_axi_rdata   = 32'h0;
    bus.mem_axi_bvalid  = 1'b0;
  endtask
  task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic ins,
                     input int da, input int dw, input int dr, input bit hold);
    bit rd = s == 4'd0;
    bit to = dr < 0;
    bit ar_ok = 0, aw_ok = 0, w_ok = 0, ar_hs = 0, aw_hs = 0, w_hs = 0, rsp_hs = 0;
    int ca = 0, caw = 0, cw = 0, cr = 0, n_ar = 0, n_aw = 0, exp_lat;
    logic [31:0] exp_rd, got_awaddr = 32'h0, got_wdata = 32'h0;
    logic [3:0] got_wstrb = 4'h0;
    exp_lat = to ? TMO + 1 : rd ? 3 + da + dr : 3 + (da > dw ? da : dw) + dr;
    exp_rd = rd ? (to ? ERR : ref_rd(a)) : last_rdata;
    if (!rd && !to) ref_mem[a] = merge(ref_rd(a), d, s);
    bus.mem_valid = 1'b1;
    bus.mem_instr = ins;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_wstrb = s;
    slave_idle();
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (ar_hs) begin ar_ok = 1; n_ar++; end
      if (aw_hs) begin aw_ok = 1; n_aw++; end
      if (w_hs) w_ok = 1;
      if (rsp_hs && !rd) slv_mem[got_awaddr] = merge(slv_rd(got_awaddr), got_wdata, got_wstrb);
      if (bus.mem_ready) begin
        chk("latency", c, exp_lat);
        chk("rdata", bus.mem_rdata, exp_rd);
        chk("err", 32'(bus.mem_err), 32'(to));
        if (to) chk("tmo_drop", 32'({bus.mem_axi_arvalid, bus.mem_axi_awvalid, bus.mem_axi_wvalid,
                                     bus.mem_axi_rready, bus.mem_axi_bready}), 32'h0);
        else begin
          chk("ar_count", n_ar, 32'(rd));
          chk("aw_count", n_aw, 32'(!rd));
        end
        if (!hold) bus.mem_valid = 1'b0;
        slave_idle();
        tick();
        chk("pulse", 32'({bus.mem_ready, bus.mem_err}), 32'h0);
        chk("no_reissue", 32'({bus.mem_axi_arvalid, bus.mem_axi_awvalid, bus.mem_axi_wvalid}), 32'h0);
        chk("idle_ready", 32'({bus.mem_axi_rready, bus.mem_axi_bready}), 32'h3);
        bus.mem_valid = 1'b0;
        last_rdata = exp_rd;
        return;
      end
      if (bus.mem_axi_arvalid) begin
        chk("araddr", bus.mem_axi_araddr, a);
        chk("arprot", 32'(bus.mem_axi_arprot), ins ? 32'h4 : 32'h0);
      end
      if (bus.mem_axi_awvalid) begin
        chk("awaddr", bus.mem_axi_awaddr, a);
        chk("awprot", 32'(bus.mem_axi_awprot), 32'h0);
      end
      if (bus.mem_axi_wvalid) begin
        chk("wdata", bus.mem_axi_wdata, d);
        chk("wstrb", 32'(bus.mem_axi_wstrb), 32'(s));
      end
      bus.mem_axi_arready = bus.mem_axi_arvalid && ca >= da;
      if (bus.mem_axi_arvalid) ca++;
      ar_hs = bus.mem_axi_arvalid && bus.mem_axi_arready;
      bus.mem_axi_awready = bus.mem_axi_awvalid && caw >= da;
      if (bus.mem_axi_awvalid) caw++;
      aw_hs = bus.mem_axi_awvalid && bus.mem_axi_awready;
      if (aw_hs) got_awaddr = bus.mem_axi_awaddr;
      bus.mem_axi_wready = bus.mem_axi_wvalid && cw >= dw;
      if (bus.mem_axi_wvalid) cw++;
      w_hs = bus.mem_axi_wvalid && bus.mem_axi_wready;
      if (w_hs) begin
        got_wdata = bus.mem_axi_wdata;
        got_wstrb = bus.mem_axi_wstrb;
      end
      bus.mem_axi_rvalid = rd && !to && ar_ok && cr >= dr;
      bus.mem_axi_rdata  = bus.mem_axi_rvalid ? slv_rd(a) : 32'h0;
      if (ar_ok) cr++;
      bus.mem_axi_bvalid = !rd && !to && aw_ok && w_ok && cr >= dr;
      if (aw_ok && w_ok) cr++;
      rsp_hs = (bus.mem_axi_rvalid && bus.mem_axi_rready) || (bus.mem_axi_bvalid && bus.mem_axi_bready);
    end
    chk("completion", 32'(bus.mem_ready), 32'h1);
    bus.mem_valid = 1'b0;
    slave_idle();
  endtask
  initial begin
    logic [3:0] rs;
    resetn = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_instr = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'h0;
    slave_idle();
    tick();
    tick();
    chk("rst_valids", 32'({bus.mem_axi_arvalid, bus.mem_axi_awvalid, bus.mem_axi_wvalid, bus.mem_ready, bus.mem_err}), 32'h0);
    chk("rst_readys", 32'({bus.mem_axi_rready, bus.mem_axi_bready}), 32'h3);
    chk("rst_rdata", bus.mem_rdata, 32'h0);
    chk("rst_addrs", bus.mem_axi_araddr | bus.mem_axi_awaddr | bus.mem_axi_wdata, 32'h0);
    chk("rst_prot_strb", 32'({bus.mem_axi_arprot, bus.mem_axi_awprot, bus.mem_axi_wstrb}), 32'h0);
    resetn = 1'b1;
    tick();
    ref_mem[32'h10] = 32'h1234_5678;
    slv_mem[32'h10] = 32'h1234_5678;
    txn(32'h0000_0010, 32'h0, 4'h0, 1'b0, 0, 0, 0, 1'b0);
    txn(32'h0000_0100, 32'h0, 4'h0, 1'b1, 0, 0, 0, 1'b0);
    txn(32'h0000_0100, 32'h0, 4'h0, 1'b0, 0, 0, 0, 1'b0);
    txn(32'h0001_0004, 32'hA5A5_A5A5, 4'b0011, 1'b0, 0, 2, 1, 1'b0);
    txn(32'h0001_0004, 32'h0, 4'h0, 1'b0, 1, 0, 2, 1'b0);
    txn(32'h0003_0000, 32'h0, 4'h0, 1'b0, 0, 0, -1, 1'b0);
    bus.mem_axi_rvalid = 1'b1;
    bus.mem_axi_rdata  = 32'hBAD0_BAD0;
    bus.mem_axi_bvalid = 1'b1;
    tick();
    slave_idle();
    chk("stale_ready", 32'({bus.mem_ready, bus.mem_err}), 32'h0);
    chk("stale_rdata", bus.mem_rdata, ERR);
    chk("stale_noissue", 32'({bus.mem_axi_arvalid, bus.mem_axi_awvalid}), 32'h0);
    tick();
    txn(32'h0003_0000, 32'h0, 4'h0, 1'b0, 0, 0, 0, 1'b0);
    txn(32'h0004_0000, 32'h0, 4'h0, 1'b1, 100, 0, -1, 1'b0);
    txn(32'h0000_0010, 32'h0, 4'h0, 1'b0, 0, 0, 0, 1'b0);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h0000_2000;
    bus.mem_wdata = 32'h1111_2222;
    bus.mem_wstrb = 4'hF;
    tick();
    chk("mid_aw_pre", 32'({bus.mem_axi_awvalid, bus.mem_axi_wvalid}), 32'h3);
    resetn = 1'b0;
    bus.mem_valid = 1'b0;
    tick();
    chk("mid_rst_valids", 32'({bus.mem_axi_arvalid, bus.mem_axi_awvalid, bus.mem_axi_wvalid, bus.mem_ready}), 32'h0);
    chk("mid_rst_readys", 32'({bus.mem_axi_rready, bus.mem_axi_bready}), 32'h3);
    resetn = 1'b1;
    last_rdata = 32'h0;
    tick();
    txn(32'h0000_0010, 32'h0, 4'h0, 1'b0, 0, 0, 0, 1'b0);
    txn(32'h0000_0010, 32'h0, 4'h0, 1'b0, 0, 0, 0, 1'b1);
    txn(32'h0000_0020, 32'h0, 4'h0, 1'b0, 0, 0, 0, 1'b1);
    txn(32'h0000_0020, 32'hCAFE_F00D, 4'hF, 1'b0, 0, 0, 0, 1'b1);
    txn(32'h0000_0020, 32'h0, 4'h0, 1'b0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      rs = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
      txn(32'h1000 + 32'($urandom_range(15, 0)) * 32'd4, $urandom, rs, 1'($urandom_range(1, 0)),
          int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axil_master_bridge.md
Name: axil_master_bridge

Overview:
- Converts the PicoRV32 native memory interface (mem_valid/mem_ready) into an AXI4-lite master that drives the SoC memory slave and peripherals.
- Sits between the CPU core and the AXI4-lite interconnect. One outstanding transaction at a time.
- Includes a response timeout. Addresses outside mapped regions get no slave response, and the timeout prevents a permanent CPU hang on those addresses.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles allowed from leaving IDLE until the transaction completes. 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF: value returned on mem_rdata for a timed-out read.

Ports:
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  synchronous active-low reset
- mem_valid  in  1  native request valid; held until mem_ready
- mem_instr  in  1  request is an instruction fetch
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte enables; 0 = read, nonzero = write
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data, valid while mem_ready=1
- mem_err  out  1  pulses with mem_ready when the transaction timed out
- mem_axi_awvalid/awready  out/in  1  write address handshake
- mem_axi_awaddr  out  32; mem_axi_awprot  out  3
- mem_axi_wvalid/wready  out/in  1; mem_axi_wdata  out  32; mem_axi_wstrb  out  4
- mem_axi_bvalid/bready  in/out  1
- mem_axi_arvalid/arready  out/in  1; mem_axi_araddr  out  32; mem_axi_arprot  out  3
- mem_axi_rvalid/rready  in/out  1; mem_axi_rdata  in  32

Behaviour:
- Clock and reset: one clock, clk. Reset resetn is synchronous and active-low.
- Registered outputs: all outputs are registered.
- Reset values:
  - All valids, mem_ready and mem_err are 0.
  - mem_rdata, addr, wdata, wstrb and prot outputs are 0.
  - rready and bready are 1 (IDLE values).
  - FSM goes to IDLE; timeout counter is 0.
- Reset mid-transaction: returns to IDLE immediately. Any in-flight AXI valid drops.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE:
  - rready=1 and bready=1. Any rvalid/bvalid seen here is stale (from a timed-out transaction) and is discarded.
  - On mem_valid=1 with wstrb==0: latch araddr=mem_addr and arprot = mem_instr ? 3'b100 : 3'b000. Set arvalid=1, go to RD_ADDR. Set rready=0.
  - On mem_valid=1 with wstrb!=0: latch awaddr, wdata, wstrb; awprot=3'b000. Set awvalid=1 and wvalid=1, go to WR_REQ. Set bready=0.
- RD_ADDR: on arvalid&&arready, set arvalid=0 and rready=1, go to RD_DATA.
- RD_DATA: on rvalid&&rready, set rready=0, mem_rdata=mem_axi_rdata and mem_ready=1, go to DONE.
- WR_REQ:
  - awvalid and wvalid retire independently: each clears on its own handshake. Simultaneous handshakes clear both in the same cycle.
  - Go to WR_RESP (bready=1) in the cycle both have completed.
  - wvalid is never held back waiting for awready, so slaves that raise wready only after AW is accepted still work.
- WR_RESP: on bvalid&&bready, set bready=0 and mem_ready=1, go to DONE. mem_rdata is unchanged on writes.
- DONE:
  - mem_ready (and mem_err, if set) clear after exactly one cycle.
  - Return to IDLE with rready=bready=1.
  - mem_valid is ignored in DONE; the next request is sampled in IDLE.
- Zero-wait-slave latency: mem_valid sampled in cycle 0, AR/AW valid in cycle 1.
  - Read: mem_ready in cycle 3 when the slave returns rvalid in cycle 2.
  - Write: mem_ready in cycle 3 when the slave returns bvalid in cycle 2.
  - Latency grows by one cycle per slave wait cycle.
- Timeout:
  - The counter clears in IDLE and increments every cycle in RD_ADDR, RD_DATA, WR_REQ and WR_RESP.
  - When it reaches TIMEOUT_CYCLES: drop all AXI valids, rready and bready. Pulse mem_ready=1 and mem_err=1. For reads, mem_rdata=ERR_RDATA. Go to DONE.
  - Dropping a valid before its ready is a deliberate bus-recovery exception to AXI rules.
  - A late response after timeout is absorbed in IDLE.
- Address and data outputs stay stable while their valid is high. They hold their last value otherwise.
- No alignment check: the address is passed through unmodified.

Test Plan:
- Zero-wait read: mem_valid, addr 0x0000_0010, wstrb 0. Slave gives arready=1, then rvalid with rdata 0x1234_5678 → mem_ready pulses 1 cycle in cycle 3, mem_rdata=0x1234_5678, mem_err=0, araddr=0x10.
- Instruction fetch: mem_instr=1, addr 0x100 → arprot=3'b100. Repeat with mem_instr=0 → arprot=3'b000.
- Split write: addr 0x0001_0004, wdata 0xA5A5_A5A5, wstrb 4'b0011. Slave gives awready in cycle 1 and wready in cycle 3 → wvalid held through cycle 3, bready rises in cycle 4. Slave gives bvalid in cycle 5 → mem_ready in cycle 6, mem_err=0.
- Timeout: TIMEOUT_CYCLES=8, read of 0x0003_0000. AR accepted, no rvalid → mem_ready=mem_err=1 exactly 8 cycles after leaving IDLE, mem_rdata=0xDEAD_BEEF. A later stale rvalid is consumed in IDLE; the next read returns correct data.
- Reset mid-transaction: resetn=0 while in WR_REQ with awvalid=1 → next edge all valids 0, rready=bready=1. Post-reset read completes normally.
- Back-to-back: mem_valid held high across requests → second arvalid asserts 2 cycles after the first mem_ready pulse. No request is issued twice.
